// File: rtl/rf_write_back_pkg.sv
// Shared types and helpers for the register-file write-back controller.
package rf_write_back_pkg;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;

  localparam logic [AW-1:0] REG_X = 5'd26;
  localparam logic [AW-1:0] REG_Y = 5'd28;
  localparam logic [AW-1:0] REG_Z = 5'd30;

  typedef struct packed {
    logic          word;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  // Pair accesses compare on the pair index; byte-to-byte needs an exact match.
  function automatic logic wb_overlap(input wb_entry_t e, input logic [AW-1:0] raddr,
                                      input logic rword);
    if (e.word || rword) return e.addr[AW-1:1] == raddr[AW-1:1];
    return e.addr == raddr;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular write-back buffer: dual enqueue (ld then ex), single dequeue per cycle.
module wb_fifo
  import rf_write_back_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_push,
  input  wb_entry_t       ld_entry,
  input  logic            ex_push,
  input  wb_entry_t       ex_entry,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   count_next,
  output wb_entry_t       head_next,
  output wb_entry_t       entries [DEPTH],
  output logic [DEPTH-1:0] vld
);

  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n, ex_ptr;
  wb_entry_t     mem   [DEPTH];
  wb_entry_t     mem_n [DEPTH];
  logic          pop;
  int unsigned   off;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop     = (count != '0);
  assign entries = mem;

  // Next storage image, pointers and count; head_next is what the port shows after the edge.
  always_comb begin
    mem_n    = mem;
    ex_ptr   = ld_push ? ptr_inc(wr_ptr) : wr_ptr;
    wr_ptr_n = wr_ptr;
    if (ld_push) begin
      mem_n[wr_ptr] = ld_entry;
      wr_ptr_n      = ptr_inc(wr_ptr);
    end
    if (ex_push) begin
      mem_n[ex_ptr] = ex_entry;
      wr_ptr_n      = ptr_inc(ex_ptr);
    end
    rd_ptr_n   = pop ? ptr_inc(rd_ptr) : rd_ptr;
    count_next = count - CW'(pop) + CW'(ld_push) + CW'(ex_push);
    head_next  = mem_n[rd_ptr_n];
  end

  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    off = 0;
    vld = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off    = (i >= 32'(rd_ptr)) ? i - 32'(rd_ptr) : i + DEPTH - 32'(rd_ptr);
      vld[i] = off < 32'(count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    mem <= mem_n;
  end

endmodule

// File: rtl/rf_write_back.sv
// Register-file write-back controller: orders ld/ex writes, drives the RF write port, flags read hazards.
module rf_write_back
  import rf_write_back_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_word,
  input  logic [4:0]  ex_addr,
  input  logic [15:0] ex_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        re_word,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic        we,
  output logic        we_word,
  output logic [4:0]  waddr,
  output logic [15:0] wdata,
  output logic        stall,
  output logic        haz_a,
  output logic        haz_b,
  output logic        ovf
);

  localparam int unsigned CW = $clog2(DEPTH + 2);

  wb_entry_t        ld_entry, ex_entry, head_next;
  wb_entry_t        entries [DEPTH];
  logic [CW-1:0]    count, count_next;
  logic [DEPTH-1:0] vld;
  logic             ld_push, ex_push;

  assign stall   = (count >= CW'(DEPTH - 1));
  assign ld_push = ld_valid & ~rst;
  assign ex_push = ex_valid & ~stall & ~rst;

  // Word writes are pair-aligned; byte writes carry a zero upper byte.
  always_comb begin
    ld_entry.word = 1'b0;
    ld_entry.addr = ld_addr;
    ld_entry.data = {8'h00, ld_data};
    ex_entry.word = ex_word;
    ex_entry.addr = ex_word ? {ex_addr[4:1], 1'b0} : ex_addr;
    ex_entry.data = ex_word ? ex_data : {8'h00, ex_data[7:0]};
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .ld_push    (ld_push),
    .ld_entry   (ld_entry),
    .ex_push    (ex_push),
    .ex_entry   (ex_entry),
    .count      (count),
    .count_next (count_next),
    .head_next  (head_next),
    .entries    (entries),
    .vld        (vld)
  );

  // Pending writes include the head being written this cycle and the requests accepted now.
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld[i]) begin
        haz_a = haz_a | wb_overlap(entries[i], raddr_a, re_word);
        haz_b = haz_b | wb_overlap(entries[i], raddr_b, 1'b0);
      end
    end
    if (ld_push) begin
      haz_a = haz_a | wb_overlap(ld_entry, raddr_a, re_word);
      haz_b = haz_b | wb_overlap(ld_entry, raddr_b, 1'b0);
    end
    if (ex_push) begin
      haz_a = haz_a | wb_overlap(ex_entry, raddr_a, re_word);
      haz_b = haz_b | wb_overlap(ex_entry, raddr_b, 1'b0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we      <= 1'b0;
      we_word <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      ovf     <= 1'b0;
    end else begin
      if (count_next != '0) begin
        we      <= 1'b1;
        we_word <= head_next.word;
        waddr   <= head_next.addr;
        wdata   <= head_next.data;
      end else begin
        we      <= 1'b0;
        we_word <= 1'b0;
        waddr   <= '0;
        wdata   <= '0;
      end
      ovf <= ovf | (ex_valid & stall);
    end
  end

endmodule

// File: tb/tb_rf_write_back.sv
// Scoreboard bench for rf_write_back: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_rf_write_back;
  import rf_write_back_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_word, ld_valid, re_word;
  logic [4:0]  ex_addr, ld_addr, raddr_a, raddr_b;
  logic [15:0] ex_data;
  logic [7:0]  ld_data;
  logic        we, we_word, stall, haz_a, haz_b, ovf;
  logic [4:0]  waddr;
  logic [15:0] wdata;

  wb_entry_t exp_q [$];
  int        checks   = 0;
  int        failures = 0;
  int        mcount   = 0;
  logic      ovf_m    = 1'b0;

  always #5 clk = ~clk;

  rf_write_back #(.DEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_word(ex_word), .ex_addr(ex_addr), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .re_word(re_word), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .we(we), .we_word(we_word), .waddr(waddr), .wdata(wdata),
    .stall(stall), .haz_a(haz_a), .haz_b(haz_b), .ovf(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every write-port transaction must match the oldest expected write.
  always @(negedge clk) begin
    wb_entry_t e;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_port", 32'({we_word, waddr, wdata}), 32'({e.word, e.addr, e.data}));
      end
    end
  end

  // One stimulus cycle; exp_ex is the hand-written entry for an accepted ex request.
  task automatic cyc(input logic lv, input logic [4:0] la, input logic [7:0] ldd,
                     input logic ev, input logic ew, input logic [4:0] ea,
                     input logic [15:0] ed, input wb_entry_t exp_ex);
    logic acc;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    ex_valid = ev; ex_word = ew; ex_addr = ea; ex_data = ed;
    #1;
    check("stall", 32'(stall), 32'(mcount >= 2));
    check("ovf", 32'(ovf), 32'(ovf_m));
    if (lv) exp_q.push_back(wb_entry_t'{1'b0, la, {8'h00, ldd}});
    acc = ev && (mcount < 2);
    if (acc) exp_q.push_back(exp_ex);
    if (ev && !acc) ovf_m = 1'b1;
    mcount = mcount - ((mcount > 0) ? 1 : 0) + int'(lv) + int'(acc);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ex_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 16'd0, '0);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_word = 0; ex_addr = 0; ex_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    re_word = 0; raddr_a = 0; raddr_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({we, we_word, waddr, wdata, stall, ovf}), 32'd0);
    rst = 1'b0;

    // Single word write to r25 lands on the aligned pair r24.
    cyc(1'b0, 5'd0, 8'd0, 1'b1, 1'b1, 5'd25, 16'hBEEF, wb_entry_t'{1'b1, 5'd24, 16'hBEEF});
    check("t1_we_next", 32'({we, we_word, waddr, wdata}), 32'({1'b1, 1'b1, 5'd24, 16'hBEEF}));
    idle(1);
    check("t1_idle", 32'(we), 32'd0);

    // ld before ex to the same register; byte ex ignores its upper data byte.
    cyc(1'b1, 5'd3, 8'h5A, 1'b1, 1'b0, 5'd3, 16'hFFA5, wb_entry_t'{1'b0, 5'd3, 16'h00A5});
    idle(3);

    // Upstream honouring stall never trips ovf.
    for (int i = 0; i < 4; i++)
      cyc((i % 2) == 0, 5'(8 + i), 8'(i), ~stall, 1'b0, 5'(16 + i), 16'(8'h30 + i),
          wb_entry_t'{1'b0, 5'(16 + i), 16'(8'h30 + i)});
    idle(3);
    check("ovf_clean", 32'(ovf), 32'd0);

    // Forced ex while stalled is dropped and sets ovf.
    cyc(1'b1, 5'd1, 8'h11, 1'b1, 1'b0, 5'd2, 16'h0022, wb_entry_t'{1'b0, 5'd2, 16'h0022});
    cyc(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 5'd4, 16'h0044, wb_entry_t'{1'b0, 5'd4, 16'h0044});
    idle(3);

    // Hazards against a pending word write to the Z pair.
    re_word = 1'b1; raddr_a = 5'd31; raddr_b = 5'd31;
    cyc(1'b0, 5'd0, 8'd0, 1'b1, 1'b1, REG_Z, 16'h1234, wb_entry_t'{1'b1, 5'd30, 16'h1234});
    check("haz_a_pair31", 32'(haz_a), 32'd1);
    check("haz_b_31", 32'(haz_b), 32'd1);
    raddr_b = 5'd29; raddr_a = 5'd28; #1;
    check("haz_b_29", 32'(haz_b), 32'd0);
    check("haz_a_pair28", 32'(haz_a), 32'd0);
    re_word = 1'b0; raddr_a = 5'd30; #1;
    check("haz_a_byte30", 32'(haz_a), 32'd1);
    idle(2);
    check("haz_a_drained", 32'(haz_a), 32'd0);
    ld_valid = 1'b1; ld_addr = REG_X; raddr_b = 5'd26; #1;
    check("haz_b_incoming_ld", 32'(haz_b), 32'd1);
    cyc(1'b1, REG_X, 8'h77, 1'b0, 1'b0, 5'd0, 16'd0, '0);
    idle(2);

    // Reset with two entries pending discards them and clears ovf.
    cyc(1'b1, 5'd5, 8'h55, 1'b1, 1'b0, 5'd6, 16'h0066, wb_entry_t'{1'b0, 5'd6, 16'h0066});
    rst = 1'b1; ld_valid = 1'b1; ld_addr = 5'd7; ex_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_outputs", 32'({we, we_word, waddr, wdata, stall, ovf}), 32'd0);
    rst = 1'b0; ld_valid = 1'b0; ex_valid = 1'b0;
    exp_q.delete();
    mcount = 0;
    ovf_m = 1'b0;
    idle(3);
    check("rst_no_we", 32'(we), 32'd0);

    // Ten back-to-back loads exercise pointer wrap-around.
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 5'(i), 8'(8'hC0 + i), 1'b0, 1'b0, 5'd0, 16'd0, '0);
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_back.md
# rf_write_back

Register-file write-back controller for the AVR core. Collects byte and word write requests from the execute stage and from returning data-memory loads, and orders them in a small FIFO. It drives the single register-file write port one entry per cycle and flags read hazards to the decoder. It is the write-side counterpart of the register-file read address selector.

## Interface

Parameters:
- DEPTH, 3, FIFO entries (minimum 2)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute-stage write request
- ex_word  in  1  1 = register-pair write, 0 = byte write
- ex_addr  in  5  destination register
- ex_data  in  16  write data; [7:0] only for byte writes
- ld_valid  in  1  load-data return (byte write)
- ld_addr  in  5  load destination register
- ld_data  in  8  load data
- re_word  in  1  decoder port A word read
- raddr_a  in  5  decoder port A read address
- raddr_b  in  5  decoder port B read address (byte only)
- we  out  1  RF write enable
- we_word  out  1  RF pair write
- waddr  out  5  RF write address
- wdata  out  16  RF write data
- stall  out  1  upstream must hold ex_valid low
- haz_a  out  1  port A read overlaps a pending write
- haz_b  out  1  port B read overlaps a pending write
- ovf  out  1  sticky protocol-error flag

## Operation

- FIFO entry: {word, addr, data}.
- Enqueue order within one cycle: ld first, then ex. Load requests belong to older instructions.
- Load entry format: {0, ld_addr, {8'h00, ld_data}}.
- Word entries force addr[0] to 0.
- Dequeue: one entry per cycle when count > 0. The head is presented on the write port.
- Write port meaning:
  - Byte write: wdata[7:0] is written to waddr.
  - Word write: wdata[7:0] is written to waddr and wdata[15:8] to waddr+1.
  - Byte entries drive wdata[15:8] = 0.
- count_next = count − (count>0) + ld_valid + (ex_valid & ~stall).
- stall = (count ≥ DEPTH−1), derived from the registered count.
  - With this rule count never exceeds DEPTH−1.
  - ld_valid is always accepted, including while stalled.
- ex_valid while stall: the request is dropped and ovf sets. ovf is cleared only by rst.
- Hazard coverage:
  - A word entry covers {addr, addr|1}. A byte entry covers {addr}.
  - A port A word read covers {raddr_a&~1, raddr_a|1}.
  - haz_a / haz_b = overlap with any valid FIFO entry (head included) or with this cycle's accepted ld/ex request.
  - Hazards are combinational.
- Same-address writes retire in FIFO order, so the last writer wins.
- The RF has no write-through, so the head entry counts as pending in the cycle it is written.

## Timing

- Request accepted at edge k → on the write port after edge k → written into the RF at edge k+1. Minimum latency is 1 cycle.
- With both sources active and an empty FIFO: ld retires at k+1, ex at k+2.
- Reset values: count 0, we 0, we_word 0, waddr 0, wdata 0, stall 0, ovf 0.
- After reset, haz_a/haz_b follow only the incoming requests.
- Reset mid-operation: all pending entries are discarded and never written. Requests present in the reset cycle are ignored.
- FIFO pointers wrap modulo DEPTH. Full and empty are decided by count, not by pointer equality.

## Structure

- Shared package:
  - wb_entry_t struct {word, addr[4:0], data[15:0]}
  - constants REG_X=26, REG_Y=28, REG_Z=30
  - function wb_overlap(entry, raddr, rword)
- Sub-module wb_fifo:
  - DEPTH-entry circular buffer
  - dual enqueue (ld, ex), single dequeue
  - exposes count and all entries for the hazard compare
- Top level: enqueue gating, stall/ovf logic, hazard reduction.

## Test plan

- Single ex word write, addr=25, data=16'hBEEF, empty FIFO → next cycle we=1, we_word=1, waddr=24, wdata=BEEF; idle the following cycle.
- ld (r3, 8'h5A) and ex byte (r3, 8'hA5) in the same cycle → r3 written 5A, then A5. stall asserts at count=2 (DEPTH=3).
- ex_valid held high for 4 cycles while ld_valid also pulses → stall asserts. Upstream honouring stall leaves ovf=0. A forced ex_valid during stall drops the request and sets ovf=1 until rst.
- Pending word write to r30 → haz_a=1 for re_word=1 with raddr_a=31. haz_b=1 for raddr_b=31. haz_b=0 for raddr_b=29.
- rst asserted with 2 entries pending → no further we. All outputs return to 0 on the next edge.
- Wrap-around: 10 back-to-back byte writes r0..r9 with ld only → each is written exactly once, in order.
